ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Bus initiator for the 256-word RAM. Accepts a byte stream over a valid/ready handshake and packs each pair of bytes into a 16-bit word, high byte first.
- Writes the words to consecutive RAM addresses from 0. It then reads every loaded word back and checks a modulo-2^16 sum.
- Sits between the UART receiver and the RAM address/in/load/out port. While busy it holds the CPU off the RAM.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM word width. Fixed at 2 bytes per word.
- WORD_COUNT, 256, number of words per load. Legal range is 1..2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load. Accepted only in IDLE or DONE.
- byte_valid  in  1  upstream byte present.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- ram_address  out  ADDR_W  RAM address.
- ram_in  out  DATA_W  RAM write data.
- ram_load  out  1  RAM write enable.
- ram_out  in  DATA_W  RAM read data. Combinational read of ram_address, same cycle.
- busy  out  1  load or verify in progress. Used as the CPU hold / bus grant.
- done  out  1  load and verify complete.
- error  out  1  verify sum mismatch. Meaningful only while done=1.

Behaviour:
- Handshake: a byte transfers on a rising edge where byte_valid=1 and byte_ready=1. byte_ready is decoded from state only and never depends on byte_valid. byte_data is ignored when no transfer occurs.
- Registers:
  - state
  - addr (ADDR_W)
  - hi (8 bits)
  - lo (8 bits)
  - wsum (16 bits)
  - rsum (16 bits)
  - error
- Outputs decoded from registers:
  - ram_address = addr
  - ram_in = {hi, lo}
  - ram_load = (state==WRITE)
  - busy = state in {RX_HI, RX_LO, WRITE, VERIFY}
  - done = (state==DONE)
- Reset (asynchronous, any time, including mid-load or mid-verify):
  - state=IDLE; addr, hi, lo, wsum, rsum and error all 0.
  - All outputs are therefore 0.
  - RAM words already written stay written.
- IDLE: byte_ready=0.
  - start=1 -> RX_HI; addr, wsum, rsum and error cleared.
- RX_HI: byte_ready=1.
  - On transfer, hi<=byte_data -> RX_LO. Otherwise stay.
- RX_LO: byte_ready=1.
  - On transfer, lo<=byte_data -> WRITE. Otherwise stay.
- WRITE: byte_ready=0, ram_load=1 for exactly one cycle; wsum<=wsum+{hi,lo} (mod 2^16).
  - If addr==WORD_COUNT-1: addr<=0 -> VERIFY.
  - Else: addr<=addr+1 -> RX_HI.
- VERIFY: byte_ready=0, ram_load=0. Each cycle rsum<=rsum+ram_out (mod 2^16).
  - If addr==WORD_COUNT-1 -> DONE, with error<=((rsum+ram_out)!=wsum).
  - Else: addr<=addr+1.
  - Takes exactly WORD_COUNT cycles.
- DONE: done=1, error held, busy=0.
  - start=1 -> RX_HI, clearing everything as from IDLE.
- start while busy is ignored and has no effect.
- Throughput: the minimum is 3 cycles per word when bytes arrive back to back.
  - Full load plus verify is at least 3*WORD_COUNT + WORD_COUNT cycles.
  - The edge that accepts start is not counted.
- Address never wraps: the counter stops at WORD_COUNT-1.
- For WORD_COUNT=256 with ADDR_W=8, the terminal compare is against 8'hFF. It must not be an overflow-based test.
- A stalled upstream (byte_valid=0) holds state indefinitely. There is no timeout.

Decomposition:
- Shared package: the state encoding as a localparam/enum with IDLE=0, RX_HI=1, RX_LO=2, WRITE=3, VERIFY=4, DONE=5, plus the byte width constant (8).
- No sub-module is needed; the block is a single FSM with datapath registers.
- Bench and top-level instantiate RAM256 alongside it.

Test Plan:
- Basic load, WORD_COUNT=4:
  - Stimulus: start, then bytes 12 34 56 78 9A BC DE F0 back to back.
  - RAM[0..3] = 1234, 5678, 9ABC, DEF0.
  - ram_load pulses 4 times, one cycle each.
  - done rises 16 cycles after start accepted (12 load + 4 verify), with error=0.
- Stalled source, WORD_COUNT=4:
  - Stimulus: byte_valid toggled 1/0 every cycle.
  - Same RAM contents as the basic load; byte_ready stays 1 through each gap.
  - done rises with error=0.
- Verify fault injection:
  - Stimulus: force ram_out bit 0 inverted at address 2 during VERIFY.
  - done=1 with error=1; rsum differs from wsum by 1.
- Full 256-word load, word = address*257 (bytes aa aa):
  - All 256 words correct; addr stops at FF without wrapping.
  - done after 1024 cycles, error=0.
  - start during busy is ignored: a pulse mid-load does not restart it.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges during RX_LO of word 3.
  - Outputs go to 0 immediately; RAM[0..2] are retained.
  - A new start then reloads from address 0 and completes with done=1, error=0.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM loader: state encoding and byte width.
package ram_loader_pkg;

    localparam int unsigned BYTE_W = 8;

    // Loader sequencing states; encoding is fixed so debug views stay stable.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RX_HI  = 3'd1,
        RX_LO  = 3'd2,
        WRITE  = 3'd3,
        VERIFY = 3'd4,
        DONE   = 3'd5
    } state_t;

    // True while the loader owns the RAM port and the CPU must be held off.
    function automatic logic state_busy(input state_t s);
        return (s == RX_HI) || (s == RX_LO) || (s == WRITE) || (s == VERIFY);
    endfunction

    // True in the states that take a byte from the upstream source.
    function automatic logic state_rx(input state_t s);
        return (s == RX_HI) || (s == RX_LO);
    endfunction

endpackage

// File: rtl/ram_loader.sv
// Byte-stream RAM loader: packs byte pairs into words, writes them from
// address 0 upward, then reads everything back and compares checksums.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned WORD_COUNT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Terminal address is an explicit compare so the counter never relies on wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    // Reject configurations the datapath cannot represent.
    if (DATA_W != 2 * BYTE_W) begin : g_bad_data_w
        $error("ram_loader: DATA_W must be exactly two bytes");
    end
    if (WORD_COUNT < 1 || WORD_COUNT > (1 << ADDR_W)) begin : g_bad_count
        $error("ram_loader: WORD_COUNT outside 1..2^ADDR_W");
    end

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [BYTE_W-1:0]   hi;
    logic [BYTE_W-1:0]   lo;
    logic [DATA_W-1:0]   wsum;
    logic [DATA_W-1:0]   rsum;
    logic                err_q;

    logic                at_last;
    logic [DATA_W-1:0]   word;
    logic [DATA_W-1:0]   rsum_next;

    assign at_last   = (addr == LAST_ADDR);
    assign word      = DATA_W'({hi, lo});
    assign rsum_next = rsum + ram_out;

    // Sequencer and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            hi    <= '0;
            lo    <= '0;
            wsum  <= '0;
            rsum  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RX_HI;
                        addr  <= '0;
                        wsum  <= '0;
                        rsum  <= '0;
                        err_q <= 1'b0;
                    end
                end
                RX_HI: begin
                    if (byte_valid) begin
                        hi    <= byte_data;
                        state <= RX_LO;
                    end
                end
                RX_LO: begin
                    if (byte_valid) begin
                        lo    <= byte_data;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    wsum <= wsum + word;
                    if (at_last) begin
                        addr  <= '0;
                        state <= VERIFY;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= RX_HI;
                    end
                end
                VERIFY: begin
                    rsum <= rsum_next;
                    if (at_last) begin
                        err_q <= (rsum_next != wsum);
                        state <= DONE;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Port decode straight from registers; nothing here looks at live inputs.
    assign byte_ready  = state_rx(state);
    assign ram_address = addr;
    assign ram_in      = word;
    assign ram_load    = (state == WRITE);
    assign busy        = state_busy(state);
    assign done        = (state == DONE);
    assign error       = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (4-word and 256-word loads), each with
// a behavioural 256-word RAM with combinational read.
module tb_ram_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start      [2];
    logic          byte_valid [2];
    logic [7:0]    byte_data  [2];
    logic          byte_ready [2];
    logic [AW-1:0] ram_address[2];
    logic [DW-1:0] ram_in     [2];
    logic          ram_load   [2];
    logic [DW-1:0] ram_out    [2];
    logic          busy       [2];
    logic          done       [2];
    logic          error      [2];
    logic          fault_en   [2];
    logic          scrub      [2];

    logic [DW-1:0] mem [2][256];
    int            ld_cnt     [2];
    int            ld_run_bad [2];
    bit            prev_load  [2];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    tx_q[$];
    logic [DW-1:0] exp_w[$];

    ram_loader #(.ADDR_W(AW), .DATA_W(DW), .WORD_COUNT(4)) dut4 (
        .clk(clk), .reset(reset), .start(start[0]),
        .byte_valid(byte_valid[0]), .byte_data(byte_data[0]), .byte_ready(byte_ready[0]),
        .ram_address(ram_address[0]), .ram_in(ram_in[0]), .ram_load(ram_load[0]),
        .ram_out(ram_out[0]), .busy(busy[0]), .done(done[0]), .error(error[0])
    );

    ram_loader #(.ADDR_W(AW), .DATA_W(DW), .WORD_COUNT(256)) dut256 (
        .clk(clk), .reset(reset), .start(start[1]),
        .byte_valid(byte_valid[1]), .byte_data(byte_data[1]), .byte_ready(byte_ready[1]),
        .ram_address(ram_address[1]), .ram_in(ram_in[1]), .ram_load(ram_load[1]),
        .ram_out(ram_out[1]), .busy(busy[1]), .done(done[1]), .error(error[1])
    );

    function automatic logic [DW-1:0] scrub_val(input int i);
        return 16'hA5A5 ^ DW'(i * 3);
    endfunction

    // RAM write port, optional scrub, and write-strobe bookkeeping.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (scrub[k]) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= scrub_val(i);
            end else if (ram_load[k]) begin
                mem[k][ram_address[k]] <= ram_in[k];
            end
            if (ram_load[k]) ld_cnt[k] <= ld_cnt[k] + 1;
            if (ram_load[k] && prev_load[k]) ld_run_bad[k] <= ld_run_bad[k] + 1;
            prev_load[k] <= ram_load[k];
        end
    end

    // Combinational read; optional bit-0 flip at address 2 while reading back.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ram_out[k] = mem[k][ram_address[k]] ^
                DW'(fault_en[k] && busy[k] && !byte_ready[k] && !ram_load[k] &&
                    ram_address[k] == AW'(2));
        end
    end

    // Reference: error flag is whether readback sum differs from written sum.
    function automatic bit model_error(input logic [DW-1:0] w[$], input int fault_addr);
        logic [DW-1:0] sw;
        logic [DW-1:0] sr;
        sw = '0;
        sr = '0;
        foreach (w[i]) begin
            sw = sw + w[i];
            sr = sr + (w[i] ^ DW'(i == fault_addr));
        end
        return sw != sr;
    endfunction

    task automatic load_words(input int n, input bit rnd, input int base);
        logic [DW-1:0] w;
        tx_q.delete();
        exp_w.delete();
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom) : DW'(base + i * 16'h1111);
            exp_w.push_back(w);
            tx_q.push_back(w[15:8]);
            tx_q.push_back(w[7:0]);
        end
    endtask

    task automatic do_scrub(input int sel);
        scrub[sel] = 1'b1;
        @(posedge clk); #1;
        scrub[sel] = 1'b0;
    endtask

    // Pulses start, then streams tx_q; returns edges from start acceptance to done.
    task automatic run_load(input int sel, input bit stall, input int stop_after,
                            input int poke_at, output int cycles, output int gap_bad,
                            output bit timed_out);
        int nx;
        bit xfer;
        bit prev_gap;
        cycles = 0; gap_bad = 0; nx = 0; timed_out = 1'b0; prev_gap = 1'b0;
        start[sel] = 1'b1;
        @(posedge clk); #1;
        start[sel] = 1'b0;
        while (1) begin
            if (done[sel]) break;
            if (stop_after != 0 && nx == stop_after) break;
            if (cycles >= 5000) begin timed_out = 1'b1; break; end
            byte_valid[sel] = (tx_q.size() != 0) && (!stall || (cycles % 2) == 0);
            byte_data[sel]  = byte_valid[sel] ? tx_q[0] : 8'($urandom);
            start[sel]      = (poke_at > 0 && cycles == poke_at);
            #1;
            if (stall && prev_gap && !byte_ready[sel]) gap_bad++;
            xfer     = byte_valid[sel] && byte_ready[sel];
            prev_gap = byte_ready[sel] && !byte_valid[sel];
            @(posedge clk); #1;
            cycles++;
            if (xfer) begin
                void'(tx_q.pop_front());
                nx++;
            end
        end
        byte_valid[sel] = 1'b0;
        start[sel]      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({busy[k], done[k], error[k], byte_ready[k], ram_load[k]} !== 5'b0 ||
                ram_address[k] !== '0 || ram_in[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: busy=%b done=%b err=%b rdy=%b ld=%b addr=%h in=%h, required all 0",
                         k, busy[k], done[k], error[k], byte_ready[k], ram_load[k], ram_address[k], ram_in[k]);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc, gb, l0, r0, bad;
        bit to;
        do_scrub(0);
        tx_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        exp_w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        l0 = ld_cnt[0]; r0 = ld_run_bad[0];
        run_load(0, 1'b0, 0, 0, cyc, gb, to);
        n_checks++;
        if (to || cyc != 16) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles (timeout=%0b), required 16", cyc, to);
        end
        n_checks++;
        if (done[0] !== 1'b1 || error[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status: done=%b err=%b busy=%b, required 1 0 0", done[0], error[0], busy[0]);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[0][i] !== exp_w[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL basic_ram: %0d bad words, RAM[0..3]=%h %h %h %h, required 1234 5678 9abc def0",
                     bad, mem[0][0], mem[0][1], mem[0][2], mem[0][3]);
        end
        n_checks++;
        if (ld_cnt[0] - l0 != 4 || ld_run_bad[0] != r0) begin
            n_fail++;
            $display("FAIL basic_load_pulses: %0d pulses, %0d multi-cycle, required 4 and 0",
                     ld_cnt[0] - l0, ld_run_bad[0] - r0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, gb, bad;
        bit to;
        for (int r = 0; r < 3; r++) begin
            load_words(4, 1'b1, 0);
            run_load(0, 1'b0, 0, 0, cyc, gb, to);
            bad = 0;
            for (int i = 0; i < 4; i++) if (mem[0][i] !== exp_w[i]) bad++;
            n_checks++;
            if (to || cyc != 16 || bad != 0) begin
                n_fail++;
                $display("FAIL b2b_load[%0d]: cycles=%0d bad_words=%0d timeout=%0b, required 16 0 0", r, cyc, bad, to);
            end
            n_checks++;
            if (done[0] !== 1'b1 || error[0] !== model_error(exp_w, -1)) begin
                n_fail++;
                $display("FAIL b2b_status[%0d]: done=%b err=%b, required 1 %b", r, done[0], error[0], model_error(exp_w, -1));
            end
        end
    endtask

    task automatic test_stall();
        int cyc, gb, bad;
        bit to;
        do_scrub(0);
        load_words(4, 1'b1, 0);
        run_load(0, 1'b1, 0, 0, cyc, gb, to);
        n_checks++;
        if (gb != 0) begin
            n_fail++;
            $display("FAIL stall_ready_gap: byte_ready dropped %0d times in gaps, required 0", gb);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[0][i] !== exp_w[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_ram: %0d bad words, required 0", bad);
        end
        n_checks++;
        if (to || cyc <= 16 || done[0] !== 1'b1 || error[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_status: cycles=%0d timeout=%0b done=%b err=%b, required >16 0 1 0",
                     cyc, to, done[0], error[0]);
        end
    endtask

    task automatic test_fault();
        int cyc, gb, bad;
        bit to;
        load_words(4, 1'b0, 16'h0102);
        fault_en[0] = 1'b1;
        run_load(0, 1'b0, 0, 0, cyc, gb, to);
        fault_en[0] = 1'b0;
        n_checks++;
        if (to || done[0] !== 1'b1 || error[0] !== model_error(exp_w, 2)) begin
            n_fail++;
            $display("FAIL fault_error: done=%b err=%b timeout=%0b, required 1 %b 0",
                     done[0], error[0], to, model_error(exp_w, 2));
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[0][i] !== exp_w[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fault_ram: %0d bad words, required 0", bad);
        end
    endtask

    task automatic test_full();
        int cyc, gb, bad, l0;
        bit to;
        do_scrub(1);
        tx_q.delete();
        exp_w.delete();
        for (int i = 0; i < 256; i++) begin
            exp_w.push_back(DW'(i * 257));
            tx_q.push_back(8'(i));
            tx_q.push_back(8'(i));
        end
        l0 = ld_cnt[1];
        run_load(1, 1'b0, 0, 400, cyc, gb, to);
        n_checks++;
        if (to || cyc != 1024) begin
            n_fail++;
            $display("FAIL full_latency: got %0d cycles (timeout=%0b), required 1024", cyc, to);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[1][i] !== exp_w[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_ram: %0d bad words, required 0", bad);
        end
        n_checks++;
        if (done[1] !== 1'b1 || error[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_status: done=%b err=%b, required 1 0", done[1], error[1]);
        end
        n_checks++;
        if (ram_address[1] !== 8'hFF) begin
            n_fail++;
            $display("FAIL full_addr_stop: address=%h, required ff", ram_address[1]);
        end
        n_checks++;
        if (ld_cnt[1] - l0 != 256) begin
            n_fail++;
            $display("FAIL full_load_pulses: %0d, required 256", ld_cnt[1] - l0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, gb, bad;
        bit to;
        logic [DW-1:0] old_w[$];
        do_scrub(0);
        load_words(4, 1'b0, 16'h4000);
        old_w = exp_w;
        run_load(0, 1'b0, 7, 0, cyc, gb, to);
        n_checks++;
        if (to || busy[0] !== 1'b1 || byte_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: busy=%b rdy=%b timeout=%0b, required 1 1 0", busy[0], byte_ready[0], to);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy[0], done[0], error[0], byte_ready[0], ram_load[0]} !== 5'b0 ||
            ram_address[0] !== '0 || ram_in[0] !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: busy=%b done=%b err=%b rdy=%b ld=%b addr=%h in=%h, required all 0",
                     busy[0], done[0], error[0], byte_ready[0], ram_load[0], ram_address[0], ram_in[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 3; i++) if (mem[0][i] !== old_w[i]) bad++;
        if (mem[0][3] !== scrub_val(3)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_retained: %0d bad words, RAM[3]=%h required %h", bad, mem[0][3], scrub_val(3));
        end
        load_words(4, 1'b1, 0);
        run_load(0, 1'b0, 0, 0, cyc, gb, to);
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[0][i] !== exp_w[i]) bad++;
        n_checks++;
        if (to || cyc != 16 || bad != 0 || done[0] !== 1'b1 || error[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_reload: cycles=%0d bad=%0d done=%b err=%b timeout=%0b, required 16 0 1 0 0",
                     cyc, bad, done[0], error[0], to);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; byte_valid[k] = 1'b0; byte_data[k] = '0;
            fault_en[k] = 1'b0; scrub[k] = 1'b0;
        end
        reset = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_fault();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

endmodule
